data_mem: RTL and testbench
===========================

# data_mem

Word-addressed data memory for the processor's load/store path. It provides one synchronous write port and one combinational read port on a single clock. Reset clears every location asynchronously, so a read immediately after reset returns zero. The processor datapath drives address, write strobe and write data directly and consumes `rdata` in the same cycle.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32 (from `defines.v`): width of the `addr` input.
- `WORD_WIDTH`, default 32 (from `defines.v`): width of each stored word and of the data ports.
- `DEPTH`, default 256: number of words stored. Must be a power of two, 2 ≤ `DEPTH` ≤ 2^`ADDR_WIDTH`.

Ports:
- `clk`  in  1  Sole clock. All writes occur on its rising edge.
- `rst_n`  in  1  Reset. Asynchronous, active-low.
- `addr`  in  `ADDR_WIDTH`  Word address shared by the read and write ports.
- `write`  in  1  Write enable, active-high.
- `wdata`  in  `WORD_WIDTH`  Data to write.
- `rdata`  out  `WORD_WIDTH`  Read data at `addr`.

Declaration order for positional instantiation: `clk, addr, write, wdata, rdata, rst_n`.

## Operation

- Storage: `DEPTH` words of `WORD_WIDTH` bits.
- Index = `addr[log2(DEPTH)-1:0]`. The address is a word address with no byte offset.
- Upper address bits are ignored, so addresses wrap modulo `DEPTH` (for example, `addr = DEPTH+1` aliases word 1).
- Write: at a rising `clk` edge with `rst_n=1` and `write=1`, `mem[index] <= wdata`.
- No write occurs when `write=0`.
- Read: `rdata = mem[index]`, purely combinational.
- `rdata` changes whenever `addr` changes or the addressed word is updated.
- Reset: `rst_n=0` immediately clears every word to 0, independent of `clk`.
  - While `rst_n=0`, writes are ignored and `rdata` = 0.
  - Contents remain 0 after `rst_n` deasserts until written.
- No byte enables: every write updates the full word.

## Timing

- Write latency is one edge: data is stored at the rising edge that samples `write=1`.
- Read latency is zero cycles (combinational from `addr` to `rdata`).
- Read-during-write to the same index:
  - Before the edge, `rdata` shows the old word.
  - After the edge, `rdata` shows `wdata` within the same cycle, with no bypass or forwarding logic.
- Read-during-write to a different index: `rdata` is unaffected by the write.
- Back-to-back writes on consecutive edges are allowed. Each edge commits its own `addr`/`wdata`, and the last write to an index wins.
- Reset mid-operation: assertion clears all contents within the same delta, with no clock needed.
  - A write edge coinciding with `rst_n=0` is discarded.
  - The first write is accepted at the first rising edge after `rst_n` returns to 1.
- Reset output values: `rdata` = 0.
- `addr`, `write` and `wdata` must be stable around the rising edge. There are no other handshake signals.

## Test plan

- Reset: hold `rst_n=0`, sweep `addr` 0, 1, 2, `DEPTH-1` -> `rdata` = 0 each time. A write attempted during reset leaves the word at 0.
- Basic write and readback: `write=1`, `addr=1`, `wdata=0x00000002` for one edge; then `write=0`, `addr=1` -> `rdata` = 0x00000002. `addr=2` -> `rdata` = 0x00000000.
- Write disable: `write=0`, `addr=1`, `wdata=0xDEADBEEF` over several edges -> `rdata` at `addr=1` stays 0x00000002.
- Back-to-back and overwrite: write 0x11 to addr 3, then 0x22 to addr 4, then 0x33 to addr 3 on consecutive edges -> addr 3 reads 0x33 and addr 4 reads 0x22.
- Wrap-around and same-index read-during-write:
  - Write 0xA5 to `addr=DEPTH+5` -> `addr=5` reads 0xA5.
  - With `addr=5`, `write=1`, `wdata=0x5A`: `rdata` reads 0xA5 before the edge and 0x5A after it.
- Reset mid-operation: after the writes above, pulse `rst_n=0` between clock edges -> `rdata` drops to 0 immediately. Addresses 1, 3, 4 and 5 all read 0 after release.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: word-addressed data memory with one synchronous write port, one
// combinational read port and an asynchronous clear of every word on reset.
`timescale 1ns/1ps
module data_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int WORD_WIDTH = 32,
   parameter int DEPTH      = 256
) (
   input  logic                  clk,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  write,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata,
   input  logic                  rst_n
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDX_W-1:0]      idx;
   logic [WORD_WIDTH-1:0] mem_q [DEPTH];

   // Upper address bits are deliberately dropped so addresses alias modulo DEPTH.
   assign idx = addr[IDX_W-1:0];

   generate
      if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IDX_W];
      end
   endgenerate

   // NOTE: every word sits inside the async reset branch, so contents clear the
   // instant rst_n falls and any write edge seen during reset is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (write) begin
         mem_q[idx] <= wdata;
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized and directed stimulus against an array model; a
// monitor process drains a scoreboard queue of expected read values.
`timescale 1ns/1ps
module tb_data_mem;

   localparam int AW    = 32;
   localparam int WW    = 32;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          write;
   logic [AW-1:0] addr;
   logic [WW-1:0] wdata;
   logic [WW-1:0] rdata;

   data_mem #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .addr  (addr),
      .write (write),
      .wdata (wdata),
      .rdata (rdata),
      .rst_n (rst_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WW-1:0] exp;
      string         name;
   } exp_t;

   exp_t          sb_q [$];
   event          sample_ev;
   int            errors = 0;
   int            checks = 0;
   logic [WW-1:0] ref_mem [DEPTH];

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: a plain array indexed by the address modulo DEPTH.
   function automatic void ref_clear();
      foreach (ref_mem[i]) ref_mem[i] = '0;
   endfunction

   function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem[a % DEPTH];
   endfunction

   exp_t mon_e;
   initial begin
      forever begin
         @(sample_ev);
         while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, rdata, mon_e.exp);
         end
      end
   end

   task automatic expect_read(input string name);
      exp_t e;
      #1;
      e.exp  = ref_read(addr);
      e.name = name;
      sb_q.push_back(e);
      ->sample_ev;
      #1;
   endtask

   task automatic set_read(input logic [AW-1:0] a, input string name);
      addr  = a;
      write = 1'b0;
      expect_read(name);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      write = 1'b1;
      @(posedge clk);
      if (rst_n) ref_mem[a % DEPTH] = d;
      #1;
      write = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] ra;
      rst_n = 1'b0;
      write = 1'b0;
      addr  = '0;
      wdata = '0;
      ref_clear();
      #3;
      set_read(0, "rst_a0");
      set_read(1, "rst_a1");
      set_read(2, "rst_a2");
      set_read(DEPTH - 1, "rst_alast");

      // Write attempted while reset is held must be dropped.
      do_write(7, 32'hFFFF_FFFF);
      set_read(7, "rst_write_ignored");
      @(negedge clk);
      rst_n = 1'b1;

      do_write(1, 32'h0000_0002);
      set_read(1, "basic_a1");
      set_read(2, "basic_a2");

      @(negedge clk);
      addr  = 1;
      write = 1'b0;
      wdata = 32'hDEAD_BEEF;
      repeat (3) @(posedge clk);
      expect_read("write_disable");

      do_write(3, 32'h11);
      do_write(4, 32'h22);
      do_write(3, 32'h33);
      set_read(3, "b2b_a3");
      set_read(4, "b2b_a4");

      do_write(DEPTH + 5, 32'hA5);
      set_read(5, "wrap_a5");

      @(negedge clk);
      addr  = 5;
      write = 1'b1;
      wdata = 32'h5A;
      expect_read("rdw_before");
      @(posedge clk);
      ref_mem[5] = 32'h5A;
      expect_read("rdw_after");
      write = 1'b0;

      @(negedge clk);
      #2;
      rst_n = 1'b0;
      ref_clear();
      expect_read("rst_mid_immediate");
      @(negedge clk);
      rst_n = 1'b1;
      set_read(1, "post_rst_a1");
      set_read(3, "post_rst_a3");
      set_read(4, "post_rst_a4");
      set_read(5, "post_rst_a5");
      do_write(9, 32'h99);
      set_read(9, "first_write_after_rst");

      repeat (300) begin
         ra = ($urandom_range(0, 1) != 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
         if ($urandom_range(0, 2) != 0) do_write(ra, $urandom);
         ra = ($urandom_range(0, 1) != 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
         set_read(ra, "rand_read");
      end

      #5;
      check("sb_drain", WW'(sb_q.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
